sdp_ram_pipe: RTL and testbench
===============================

// Module: sdp_ram_pipe
// PURPOSE
// Single-clock simple-dual-port RAM for the UDP datapath; successor to the async-read two-clock RAM.
// Adds registered read with 1- or 2-cycle latency and an rd_valid flag, per-byte write enables, and a
// selectable read-during-write policy. A reset-time clear engine zeroes the whole array.
// Serves as packet/header buffer storage beneath the UDP TX/RX framers.
// PARAMETERS
// ADDR_WIDTH      10   address bits; depth = 2**ADDR_WIDTH
// DATA_WIDTH      64   word width; must be a multiple of BYTE_WIDTH
// BYTE_WIDTH      8    bits per write-enable lane; NBE = DATA_WIDTH/BYTE_WIDTH
// RD_LATENCY      1    1 or 2; cycles from rd_ena sample to rd_valid
// RDW_MODE        0    0 = WRITE_FIRST (bypass new data), 1 = READ_FIRST (old data)
// CLEAR_ON_RESET  1    1 = zero all words after reset; 0 = contents undefined, no clear
// PORTS
// clk       in   1           single clock, all logic on rising edge
// rst       in   1           synchronous, active-high reset
// wr_ena    in   1           write request
// wr_be     in   NBE         byte-lane enables; bit i covers wr_data[i*BYTE_WIDTH +: BYTE_WIDTH]
// wr_addr   in   ADDR_WIDTH  write address
// wr_data   in   DATA_WIDTH  write data
// rd_ena    in   1           read request
// rd_addr   in   ADDR_WIDTH  read address
// rd_data   out  DATA_WIDTH  read data, qualified by rd_valid
// rd_valid  out  1           one-cycle pulse per accepted read
// init_busy out  1           high while clear engine runs; requests are ignored
// BEHAVIOUR
// - Reset values: rd_data=0, rd_valid=0, read pipeline flushed, init_busy=CLEAR_ON_RESET, clr_cnt=0.
// - FSM states: CLEAR, READY. rst forces CLEAR if CLEAR_ON_RESET=1, else READY.
// - CLEAR writes 0 to ram[clr_cnt] every cycle and increments clr_cnt.
// - CLEAR exits to READY after the write at clr_cnt = 2**ADDR_WIDTH-1, i.e. exactly 2**ADDR_WIDTH cycles.
//   init_busy deasserts in the first READY cycle.
// - rst asserted mid-CLEAR restarts clearing from address 0. rst mid-read drops in-flight reads (no rd_valid).
// - CLEAR: wr_ena and rd_ena are ignored; nothing is queued and no rd_valid is produced.
// - Write (READY): when wr_ena=1, lanes with wr_be[i]=1 are updated at the edge; other lanes are kept.
//   wr_be=0 is a no-op.
// - Read (READY): rd_ena sampled at edge N gives rd_data/rd_valid valid after edge N+RD_LATENCY.
//   - Back-to-back reads are allowed every cycle; throughput is one word per clock.
//   - rd_valid pulses once per accepted read.
// - rd_data holds its last value while rd_valid=0.
// - RD_LATENCY=2 adds an output register stage: data and valid are both delayed one cycle, in lockstep.
// - Same-address read and write in the same cycle:
//   - WRITE_FIRST: returned word = enabled lanes from wr_data, disabled lanes from the stored word.
//   - READ_FIRST: returned word = the stored word before the write.
// - Different addresses in the same cycle: independent, no interaction.
// - Address wrap: the full 2**ADDR_WIDTH range is valid; no bounds checking.
// - Illegal params (RD_LATENCY not 1/2, DATA_WIDTH%BYTE_WIDTH!=0): elaboration-time $error.
// STRUCTURE
// - Package udp_ram_pkg: RDW_WRITE_FIRST=0 and RDW_READ_FIRST=1 constants; state enum {CLEAR, READY}.
// - Sub-module sdp_ram_core:
//   - Byte-enable write array with 1-cycle registered read and no policy logic.
//   - Must infer block RAM; no vendor primitives.
// - Top level owns: clear FSM and counter, write mux (clear vs. user), RDW bypass compare/merge,
//   valid pipeline, optional output stage.
// TESTING
// 1 Reset, CLEAR_ON_RESET=1, ADDR_WIDTH=4: init_busy high exactly 16 cycles; then read all 16 -> all 0.
// 2 Write 0x1122334455667788 to addr 5 with wr_be=0x0F, then wr_be=0xF0 with 0xAABBCCDD00000000:
//   read 5 -> 0xAABBCCDD55667788.
// 3 Same cycle: addr 3 holds 0x0, write 0xFF..FF (wr_be=0xFF) and read 3.
//   WRITE_FIRST -> 0xFF..FF; READ_FIRST -> 0x0.
// 4 RD_LATENCY=2, read addrs 0..7 on 8 consecutive cycles:
//   8 contiguous rd_valid pulses starting 2 cycles later, in address order.
// 5 Assert rst at clear cycle 7, release: init_busy spans a further full 2**ADDR_WIDTH cycles.
//   Writes and reads issued during CLEAR produce no rd_valid and do not alter memory.
// 6 Write addr 2**ADDR_WIDTH-1 and addr 0, read both: exact data returned, no aliasing.

Source files
------------

// File: rtl/udp_ram_pkg.sv
// udp_ram_pkg: constants and types shared by the UDP datapath RAM blocks.
// Holds the read-during-write policy codes and the clear-engine state type.
package udp_ram_pkg;

    localparam int RDW_WRITE_FIRST = 0;
    localparam int RDW_READ_FIRST  = 1;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/sdp_ram_core.sv
// sdp_ram_core: plain simple-dual-port storage array with per-byte write
// enables and a single registered read port. It has no read-during-write
// policy logic: a same-address read returns the word stored before the write.
// Ports:
//   clk       in   clock
//   i_we      in   write strobe
//   i_be      in   byte-lane enables
//   i_waddr   in   write address
//   i_wdata   in   write data
//   i_re      in   read strobe; o_rdata only changes when it is high
//   i_raddr   in   read address
//   o_rdata   out  registered read data
module sdp_ram_core #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                                clk,
    input  logic                                i_we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    i_be,
    input  logic [ADDR_WIDTH-1:0]               i_waddr,
    input  logic [DATA_WIDTH-1:0]               i_wdata,
    input  logic                                i_re,
    input  logic [ADDR_WIDTH-1:0]               i_raddr,
    output logic [DATA_WIDTH-1:0]               o_rdata
);

    localparam int NBE   = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Array write and registered read share one clocked block so the
    // tools map it onto a byte-write-enabled block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < NBE; i++) begin
                if (i_be[i]) begin
                    r_mem[i_waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= i_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sdp_ram_pipe.sv
// sdp_ram_pipe: single-clock simple-dual-port RAM with registered read
// (1 or 2 cycle latency), rd_valid flag, byte-lane writes, selectable
// read-during-write policy and a clear engine that zeroes the array after reset.
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   wr_ena     in   write request
//   wr_be      in   byte-lane enables
//   wr_addr    in   write address
//   wr_data    in   write data
//   rd_ena     in   read request
//   rd_addr    in   read address
//   rd_data    out  read data, held between reads
//   rd_valid   out  one pulse per accepted read
//   init_busy  out  clear engine running; requests are ignored
module sdp_ram_pipe
    import udp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 64,
    parameter int BYTE_WIDTH     = 8,
    parameter int RD_LATENCY     = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wr_ena,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    wr_be,
    input  logic [ADDR_WIDTH-1:0]               wr_addr,
    input  logic [DATA_WIDTH-1:0]               wr_data,
    input  logic                                rd_ena,
    input  logic [ADDR_WIDTH-1:0]               rd_addr,
    output logic [DATA_WIDTH-1:0]               rd_data,
    output logic                                rd_valid,
    output logic                                init_busy
);

    localparam int NBE = DATA_WIDTH / BYTE_WIDTH;

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("sdp_ram_pipe: RD_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("sdp_ram_pipe: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_clr_cnt;

    logic                    w_clearing;
    logic                    w_ready;
    logic                    w_usr_wr;
    logic                    w_rd_acc;
    logic                    w_we;
    logic [NBE-1:0]          w_be;
    logic [ADDR_WIDTH-1:0]   w_waddr;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [DATA_WIDTH-1:0]   w_core_rdata;
    logic [DATA_WIDTH-1:0]   w_merged;

    logic                    r_vld_p1;
    logic                    r_byp_p1;
    logic [NBE-1:0]          r_byp_be_p1;
    logic [DATA_WIDTH-1:0]   r_byp_data_p1;

    // Clear engine: one zero write per cycle, leaves after the last address.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            r_clr_cnt <= '0;
        end else if (r_state == CLEAR) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
            if (r_clr_cnt == '1) begin
                r_state <= READY;
            end
        end
    end

    assign init_busy = (r_state == CLEAR);

    // Requests in the reset cycle are dropped as well, so nothing leaks
    // into the freshly flushed pipeline.
    assign w_clearing = (r_state == CLEAR) && !rst;
    assign w_ready    = (r_state == READY) && !rst;
    assign w_usr_wr   = w_ready && wr_ena;
    assign w_rd_acc   = w_ready && rd_ena;

    assign w_we    = w_clearing || w_usr_wr;
    assign w_be    = w_clearing ? {NBE{1'b1}} : wr_be;
    assign w_waddr = w_clearing ? r_clr_cnt : wr_addr;
    assign w_wdata = w_clearing ? '0 : wr_data;

    sdp_ram_core #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_core (
        .clk     (clk),
        .i_we    (w_we),
        .i_be    (w_be),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_rd_acc),
        .i_raddr (rd_addr),
        .o_rdata (w_core_rdata)
    );

    // ---- stage p1: core read register plus captured bypass lanes ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
            r_byp_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= w_rd_acc;
            if (w_rd_acc) begin
                r_byp_p1 <= (RDW_MODE == RDW_WRITE_FIRST) && w_usr_wr && (wr_addr == rd_addr);
            end
        end
    end

    // Bypass lanes are only captured on an accepted read so the merged
    // word stays stable between reads.
    always_ff @(posedge clk) begin
        if (w_rd_acc) begin
            r_byp_be_p1   <= wr_be;
            r_byp_data_p1 <= wr_data;
        end
    end

    always_comb begin
        w_merged = w_core_rdata;
        for (int i = 0; i < NBE; i++) begin
            if (r_byp_p1 && r_byp_be_p1[i]) begin
                w_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = r_byp_data_p1[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic                  r_vld_p2;
        logic [DATA_WIDTH-1:0] r_data_p2;

        // ---- stage p2: optional output register, data and valid in lockstep ----
        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld_p2  <= 1'b0;
                r_data_p2 <= '0;
            end else begin
                r_vld_p2 <= r_vld_p1;
                if (r_vld_p1) begin
                    r_data_p2 <= w_merged;
                end
            end
        end

        assign rd_data  = r_data_p2;
        assign rd_valid = r_vld_p2;
    end else begin : g_lat1
        // The core output register is not reset; until the first read since
        // reset lands, present zero instead.
        logic r_seen_p1;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_seen_p1 <= 1'b0;
            end else if (w_rd_acc) begin
                r_seen_p1 <= 1'b1;
            end
        end

        assign rd_data  = r_seen_p1 ? w_merged : '0;
        assign rd_valid = r_vld_p1;
    end

endmodule

// File: tb/tb_sdp_ram_pipe.sv
module tb_sdp_ram_pipe;

    localparam int AW    = 4;
    localparam int DW    = 64;
    localparam int NBE   = 8;
    localparam int DEPTH = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           wr_ena = 1'b0;
    logic [NBE-1:0] wr_be = '0;
    logic [AW-1:0]  wr_addr = '0;
    logic [DW-1:0]  wr_data = '0;
    logic           rd_ena = 1'b0;
    logic [AW-1:0]  rd_addr = '0;

    logic [DW-1:0]  a_rd_data, b_rd_data;
    logic           a_rd_valid, b_rd_valid;
    logic           a_busy, b_busy;

    always #5 clk = ~clk;

    // A: latency 1, write-first.  B: latency 2, read-first.
    sdp_ram_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8),
                   .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut_a (
        .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_be(wr_be), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_ena(rd_ena), .rd_addr(rd_addr),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid), .init_busy(a_busy));

    sdp_ram_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8),
                   .RD_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut_b (
        .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_be(wr_be), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_ena(rd_ena), .rd_addr(rd_addr),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .init_busy(b_busy));

    // Reference model: memory contents, clear countdown and per-DUT
    // queues of expected read results with the cycle they must appear.
    typedef struct {
        int          due;
        logic [63:0] d;
    } rd_t;

    logic [63:0] mem_m [DEPTH];
    rd_t         qa[$];
    rd_t         qb[$];
    logic [63:0] last_a, last_b;
    bit          busy_m;
    int          clr_left;
    bit          model_on = 0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [7:0] be,
                                          input logic [63:0] nw);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++)
            if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    task automatic check_outputs();
        bit ev;
        check_eq("busy_a", {63'd0, a_busy}, {63'd0, busy_m});
        check_eq("busy_b", {63'd0, b_busy}, {63'd0, busy_m});
        ev = (qa.size() > 0) && (qa[0].due == cyc);
        if (ev) begin
            last_a = qa[0].d;
            void'(qa.pop_front());
        end
        check_eq("valid_a", {63'd0, a_rd_valid}, {63'd0, ev});
        check_eq("data_a", a_rd_data, last_a);
        ev = (qb.size() > 0) && (qb[0].due == cyc);
        if (ev) begin
            last_b = qb[0].d;
            void'(qb.pop_front());
        end
        check_eq("valid_b", {63'd0, b_rd_valid}, {63'd0, ev});
        check_eq("data_b", b_rd_data, last_b);
    endtask

    // Check the outputs of the current cycle, drive the next request,
    // advance the model across the coming edge, then move one cycle on.
    task automatic step(input logic r, input logic we, input logic [7:0] be,
                        input logic [3:0] wa, input logic [63:0] wd,
                        input logic re, input logic [3:0] ra);
        logic [63:0] old;
        rd_t e;
        if (model_on) check_outputs();
        rst = r; wr_ena = we; wr_be = be; wr_addr = wa; wr_data = wd;
        rd_ena = re; rd_addr = ra;
        if (r) begin
            model_on = 1;
            busy_m   = 1;
            clr_left = DEPTH;
            qa.delete();
            qb.delete();
            last_a = '0;
            last_b = '0;
            for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        end else if (busy_m) begin
            clr_left--;
            if (clr_left == 0) busy_m = 0;
        end else begin
            if (re) begin
                old = mem_m[ra];
                e.d   = (we && wa == ra) ? merge(old, be, wd) : old;
                e.due = cyc + 1;
                qa.push_back(e);
                e.d   = old;
                e.due = cyc + 2;
                qb.push_back(e);
            end
            if (we) mem_m[wa] = merge(mem_m[wa], be, wd);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle();
        step(0, 0, 8'h00, 4'd0, 64'd0, 0, 4'd0);
    endtask

    task automatic rand_step(input logic r);
        step(r, 1'($urandom), 8'($urandom), 4'($urandom), {$urandom, $urandom},
             1'($urandom), 4'($urandom));
    endtask

    initial begin
        @(negedge clk);
        // Reset, then random requests during CLEAR that must be ignored.
        step(1, 0, 8'h00, 4'd0, 64'd0, 0, 4'd0);
        step(1, 0, 8'h00, 4'd0, 64'd0, 0, 4'd0);
        for (int i = 0; i < 18; i++) rand_step(0);
        // Whole array reads back zero.
        for (int i = 0; i < DEPTH; i++) step(0, 0, 8'h00, 4'd0, 64'd0, 1, 4'(i));
        for (int i = 0; i < 3; i++) idle();

        // Byte-lane writes to address 5.
        step(0, 1, 8'h0F, 4'd5, 64'h1122334455667788, 0, 4'd0);
        step(0, 1, 8'hF0, 4'd5, 64'hAABBCCDD00000000, 0, 4'd0);
        step(0, 0, 8'hFF, 4'd5, 64'd0, 1, 4'd5);
        step(0, 1, 8'h00, 4'd5, 64'hDEADBEEFDEADBEEF, 0, 4'd0);
        step(0, 0, 8'h00, 4'd0, 64'd0, 1, 4'd5);
        for (int i = 0; i < 3; i++) idle();

        // Same-address read and write in one cycle.
        step(0, 1, 8'hFF, 4'd3, 64'd0, 0, 4'd0);
        step(0, 1, 8'hFF, 4'd3, 64'hFFFFFFFFFFFFFFFF, 1, 4'd3);
        step(0, 1, 8'h3C, 4'd3, 64'h0123456789ABCDEF, 1, 4'd3);
        step(0, 0, 8'h00, 4'd0, 64'd0, 1, 4'd3);
        for (int i = 0; i < 3; i++) idle();

        // Distinct data everywhere, then back-to-back reads of 0..7.
        for (int i = 0; i < DEPTH; i++)
            step(0, 1, 8'hFF, 4'(i), {32'hC0DE0000 + 32'(i), $urandom}, 0, 4'd0);
        for (int i = 0; i < 8; i++) step(0, 0, 8'h00, 4'd0, 64'd0, 1, 4'(i));
        for (int i = 0; i < 3; i++) idle();

        // Top and bottom address, no aliasing.
        step(0, 1, 8'hFF, 4'd15, 64'hF00DF00DF00DF00D, 0, 4'd0);
        step(0, 1, 8'hFF, 4'd0, 64'h0BADC0DE0BADC0DE, 0, 4'd0);
        step(0, 0, 8'h00, 4'd0, 64'd0, 1, 4'd15);
        step(0, 0, 8'h00, 4'd0, 64'd0, 1, 4'd0);
        for (int i = 0; i < 3; i++) idle();

        // Random traffic; the small array makes collisions frequent.
        for (int i = 0; i < 400; i++) rand_step(0);

        // Reset with reads in flight, then reset again at clear cycle 7.
        step(0, 0, 8'h00, 4'd0, 64'd0, 1, 4'd1);
        step(1, 0, 8'h00, 4'd0, 64'd0, 1, 4'd2);
        for (int i = 0; i < 7; i++) rand_step(0);
        step(1, 0, 8'h00, 4'd0, 64'd0, 0, 4'd0);
        for (int i = 0; i < 18; i++) rand_step(0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 8'h00, 4'd0, 64'd0, 1, 4'(i));
        for (int i = 0; i < 200; i++) rand_step(0);
        for (int i = 0; i < 4; i++) idle();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
